fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed 10-bit program counter with a decoupled fetch stage. Holds the PC, issues word-addressed reads to a synchronous instruction memory with one-cycle read latency, and buffers returned instructions with their PCs in a DEPTH-entry queue. The decode stage consumes the queue through a valid/ready handshake. Branch, jump and jump-register targets arrive as a single redirect that flushes the queue and squashes any in-flight read.

---
 rtl/fetch_queue_unit_if.sv | 27 ++
 rtl/fetch_queue_unit.sv | 95 +++++++++
 tb/tb_fetch_queue_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus: instruction-memory read port and decode-side valid/ready queue head.
interface fetch_queue_unit_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: PC, one-cycle-latency imem reads and a DEPTH-entry
// instruction queue drained by decode, with redirect flush and halt.
module fetch_queue_unit #(
    parameter int unsigned          ADDR_W   = 10,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_halt,
    input  logic                       i_redirect,
    input  logic [ADDR_W-1:0]          i_redirect_pc,
    fetch_queue_unit_if.master         bus,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_halted
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_qpc  [DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;

    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [CNT_W:0]    w_occ;

    // Issue only when the registered occupancy plus the outstanding read leaves a free slot.
    always_comb begin
        w_occ   = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
        w_req   = i_rst_n & ~i_halt & ~i_redirect & (w_occ < (CNT_W+1)'(DEPTH));
        w_valid = (r_count != '0);
        w_push  = r_inflight & ~i_redirect;
        w_pop   = w_valid & bus.instr_ready & ~i_redirect;
    end

    always_comb begin
        bus.imem_req    = w_req;
        bus.imem_addr   = r_pc;
        bus.instr_valid = w_valid;
        bus.instr       = w_valid ? r_data[r_rd] : '0;
        bus.instr_pc    = w_valid ? r_qpc[r_rd]  : '0;
        o_count         = r_count;
        o_halted        = i_rst_n & i_halt & ~r_inflight;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i] <= '0;
                r_qpc[i]  <= '0;
            end
        end else if (i_redirect) begin
            // Redirect wins: flush queue, squash the landing response, reload PC.
            r_pc       <= i_redirect_pc;
            r_inflight <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_W'(1);
            end
            if (w_push) begin
                r_data[r_wr] <= bus.imem_data;
                r_qpc[r_wr]  <= r_inflight_pc;
                r_wr         <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: expected {pc, instr} queued at each fetch, checked at each pop.
module tb_fetch_queue_unit;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [2:0]        count;
    logic              halted;
    logic [2:0]        count2;
    logic              halted2;

    int n_tests;
    int n_fail;

    exp_t              sb [$];
    exp_t              e;
    logic [ADDR_W-1:0] model_pc;
    logic [ADDR_W-1:0] w2 [4];
    int                n2;
    int                found;

    fetch_queue_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    fetch_queue_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    fetch_queue_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(10'h000)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .bus(bus), .o_count(count), .o_halted(halted)
    );

    fetch_queue_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(10'h3FE)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(1'b0), .i_redirect(1'b0),
        .i_redirect_pc(10'h000), .bus(bus2), .o_count(count2), .o_halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memories: word[a] = 0x1000 + a.
    always @(posedge clk) if (bus.imem_req)  bus.imem_data  <= 32'h1000 + 32'(bus.imem_addr);
    always @(posedge clk) if (bus2.imem_req) bus2.imem_data <= 32'h1000 + 32'(bus2.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: fetches push expectations, pops are compared, redirect/reset flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_pc = 10'h000;
        end else if (redirect) begin
            check_eq("req_during_redirect", 32'(bus.imem_req), 32'd0);
            sb.delete();
            model_pc = redirect_pc;
        end else begin
            check_eq("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
            if (bus.instr_valid && bus.instr_ready) begin
                if (sb.size() == 0) begin
                    check_eq("pop_unexpected", 32'(bus.instr_pc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_eq("pop_pc", 32'(bus.instr_pc), 32'(e.pc));
                    check_eq("pop_instr", bus.instr, e.data);
                end
            end
            if (bus.imem_req) begin
                check_eq("req_addr", 32'(bus.imem_addr), 32'(model_pc));
                sb.push_back('{pc: model_pc, data: 32'h1000 + 32'(model_pc)});
                model_pc = model_pc + 10'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus2.instr_valid && bus2.instr_ready && n2 < 4) begin
            w2[n2] = bus2.instr_pc;
            n2++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] wrap_exp [4];
        n_tests = 0; n_fail = 0; n2 = 0;
        rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        bus.instr_ready = 1'b0; bus2.instr_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_req",    32'(bus.imem_req),    32'd0);
        check_eq("rst_addr",   32'(bus.imem_addr),   32'd0);
        check_eq("rst_valid",  32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr",  bus.instr,            32'd0);
        check_eq("rst_pc",     32'(bus.instr_pc),    32'd0);
        check_eq("rst_count",  32'(count),           32'd0);
        check_eq("rst_halted", 32'(halted),          32'd0);
        check_eq("rst_addr2",  32'(bus2.imem_addr),  32'h3FE);

        // Cold start.
        next_cycle(); rst_n = 1'b1; bus.instr_ready = 1'b1;
        @(negedge clk);
        check_eq("cold_c0_req",   32'(bus.imem_req),    32'd1);
        check_eq("cold_c0_addr",  32'(bus.imem_addr),   32'd0);
        check_eq("cold_c0_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check_eq("cold_c1_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check_eq("cold_c2_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("cold_c2_pc",    32'(bus.instr_pc),    32'd0);
        check_eq("cold_c2_instr", bus.instr,            32'h1000);
        repeat (4) begin
            next_cycle(); @(negedge clk);
            check_eq("steady_count", 32'(count), 32'd1);
            check_eq("steady_req",   32'(bus.imem_req), 32'd1);
        end

        // Asynchronous reset between edges with a non-empty queue.
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("arst_count", 32'(count),           32'd0);
        check_eq("arst_addr",  32'(bus.imem_addr),   32'd0);
        check_eq("arst_req",   32'(bus.imem_req),    32'd0);
        check_eq("arst_instr", bus.instr,            32'd0);
        bus.instr_ready = 1'b0;
        @(negedge clk);
        next_cycle(); rst_n = 1'b1;

        // Backpressure from start.
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            check_eq("bp_req", 32'(bus.imem_req), (c < 4) ? 32'd1 : 32'd0);
            if (c == 0) check_eq("bp_first_addr", 32'(bus.imem_addr), 32'd0);
            if (c == 4) check_eq("bp_count3", 32'(count), 32'd3);
            if (c >= 5) check_eq("bp_count4", 32'(count), 32'd4);
            if (c >= 2) check_eq("bp_head_pc", 32'(bus.instr_pc), 32'd0);
        end
        next_cycle(); bus.instr_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_req0",   32'(bus.imem_req), 32'd0);
        check_eq("bp_rel_count4", 32'(count),        32'd4);
        next_cycle(); @(negedge clk);
        check_eq("bp_rel_req1",   32'(bus.imem_req), 32'd1);
        check_eq("bp_rel_count3", 32'(count),        32'd3);
        repeat (6) next_cycle();

        // Redirect with three queued entries and a read in flight.
        bus.instr_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            next_cycle();
            if (count == 3'd3 && bus.imem_req == 1'b0) found = 1;
        end
        check_eq("rd_setup_found", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 10'h155;
        next_cycle(); redirect = 1'b0; bus.instr_ready = 1'b1;
        @(negedge clk);
        check_eq("rd_t1_count", 32'(count),           32'd0);
        check_eq("rd_t1_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rd_t1_addr",  32'(bus.imem_addr),   32'h155);
        check_eq("rd_t1_req",   32'(bus.imem_req),    32'd1);
        next_cycle(); @(negedge clk);
        check_eq("rd_t2_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check_eq("rd_t3_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("rd_t3_pc",    32'(bus.instr_pc),    32'h155);
        check_eq("rd_t3_instr", bus.instr,            32'h1155);
        repeat (5) next_cycle();

        // Halt with one read in flight.
        halt = 1'b1;
        @(negedge clk);
        check_eq("halt_c0_req",    32'(bus.imem_req), 32'd0);
        check_eq("halt_c0_halted", 32'(halted),       32'd0);
        next_cycle(); @(negedge clk);
        check_eq("halt_c1_halted", 32'(halted),           32'd1);
        check_eq("halt_c1_valid",  32'(bus.instr_valid),  32'd1);
        repeat (3) begin
            next_cycle(); @(negedge clk);
            check_eq("halt_req",    32'(bus.imem_req), 32'd0);
            check_eq("halt_halted", 32'(halted),       32'd1);
        end
        next_cycle(); halt = 1'b0;
        #1;
        check_eq("resume_req",  32'(bus.imem_req),  32'd1);
        check_eq("resume_addr", 32'(bus.imem_addr), 32'(model_pc));
        repeat (4) next_cycle();

        // Redirect honoured while halted.
        halt = 1'b1;
        repeat (3) next_cycle();
        redirect = 1'b1; redirect_pc = 10'h200;
        next_cycle(); redirect = 1'b0;
        @(negedge clk);
        check_eq("hr_addr",   32'(bus.imem_addr), 32'h200);
        check_eq("hr_req",    32'(bus.imem_req),  32'd0);
        check_eq("hr_count",  32'(count),         32'd0);
        check_eq("hr_halted", 32'(halted),        32'd1);
        next_cycle(); halt = 1'b0;
        repeat (6) next_cycle();

        // PC wrap on the second instance.
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        check_eq("wrap_n", 32'(n2), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("wrap_pc", 32'(w2[i]), 32'(wrap_exp[i]));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
